hawk_decomp_wb: RTL and testbench

//  Writeback stage downstream of the decompression manager/decompressor. On decomp_start, writes the

---
 rtl/hacd_pkg.sv | 37 +++
 rtl/hawk_outst_cnt.sv | 42 ++++
 rtl/hawk_decomp_wb.sv | 230 +++++++++++++++++++++++
 tb/tb_hawk_decomp_wb.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hacd_pkg.sv
// Shared types and constants for the HAWK decompression writeback path.
package hacd_pkg;

   localparam int HAWK_LINE_BYTES = 64;
   localparam int HAWK_PAGE_LINES = 64;
   localparam int HAWK_PAGE_BYTES = HAWK_LINE_BYTES * HAWK_PAGE_LINES;
   localparam int HAWK_ADDR_W     = 64;
   localparam int HAWK_DATA_W     = 512;

   localparam logic [7:0] AXI_AWLEN_SINGLE = 8'd0;
   localparam logic [2:0] AXI_AWSIZE_64B   = 3'd6;
   localparam logic [1:0] AXI_BURST_INCR   = 2'b01;
   localparam logic [1:0] AXI_RESP_OKAY    = 2'b00;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FILL,
      ST_SEND,
      ST_DRAIN,
      ST_DONE,
      ST_WAIT_LOW,
      ST_ERROR
   } decomp_wb_state_t;

   typedef struct packed {
      logic [HAWK_ADDR_W-1:0] addr;
      logic                   awvalid;
      logic [HAWK_DATA_W-1:0] wdata;
      logic                   wvalid;
   } axi_wr_reqpkt_t;

   typedef struct packed {
      logic       bvalid;
      logic [1:0] bresp;
   } axi_wr_resppkt_t;

endpackage

// File: rtl/hawk_outst_cnt.sv
// Outstanding AXI write counter: +1 per issued write, -1 per B response.
module hawk_outst_cnt #(
   parameter int MAX_OUTST = 4,
   parameter int CNT_W     = $clog2(MAX_OUTST + 1)
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             inc,
   input  logic             dec,
   output logic [CNT_W-1:0] cnt,
   output logic             full_nxt,
   output logic             underflow
);

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTST);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_nxt;

   // Simultaneous inc and dec leave the count unchanged.
   always_comb begin
      cnt_nxt = cnt_q;
      if (inc && !dec && (cnt_q != CNT_MAX)) begin
         cnt_nxt = cnt_q + CNT_W'(1);
      end else if (dec && !inc && (cnt_q != '0)) begin
         cnt_nxt = cnt_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_nxt;
      end
   end

   assign cnt       = cnt_q;
   assign full_nxt  = (cnt_nxt == CNT_MAX);
   assign underflow = dec && (cnt_q == '0);

endmodule

// File: rtl/hawk_decomp_wb.sv
// Writes a decompressed 4KB page, one 64B line per single-beat AXI4 write, to the chosen way.
// Optional HAWK_DECOMP_WB_STATS_EN adds wb_cycles / wb_stall_cycles counters.
//
// state    | meaning
// IDLE     | waiting for decomp_start, page base latched on exit
// FILL     | accepting the next line from the decompressor (stalls at MAX_OUTST)
// SEND     | AW and W presented, each held until its own handshake
// DRAIN    | all lines issued, waiting for remaining B responses
// DONE     | decomp_done pulse
// WAIT_LOW | waiting for decomp_start to drop before re-arming
// ERROR    | bad or unexpected B seen; only reset leaves
module hawk_decomp_wb
   import hacd_pkg::*;
#(
   parameter int DATA_W     = HAWK_DATA_W,
   parameter int ADDR_W     = HAWK_ADDR_W,
   parameter int PAGE_LINES = HAWK_PAGE_LINES,
   parameter int MAX_OUTST  = 4
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                decomp_start,
   input  logic [ADDR_W-1:0]   wb_page_addr,
   input  logic [DATA_W-1:0]   dc_wdata,
   input  logic                dc_wvalid,
   output logic                dc_wready,
   output logic [ADDR_W-1:0]   awaddr,
   output logic [7:0]          awlen,
   output logic [2:0]          awsize,
   output logic [1:0]          awburst,
   output logic                awvalid,
   input  logic                awready,
   output logic [DATA_W-1:0]   wdata,
   output logic [DATA_W/8-1:0] wstrb,
   output logic                wlast,
   output logic                wvalid,
   input  logic                wready,
   input  logic                bvalid,
   input  logic [1:0]          bresp,
   output logic                bready,
   output logic                decomp_done,
   output logic                wb_busy,
   output logic                wb_err
`ifdef HAWK_DECOMP_WB_STATS_EN
   ,
   output logic [31:0]         wb_cycles,
   output logic [31:0]         wb_stall_cycles
`endif
);

   localparam int OUTST_W    = $clog2(MAX_OUTST + 1);
   localparam int LCNT_W     = $clog2(PAGE_LINES) + 1;
   localparam int LINE_SHIFT = $clog2(HAWK_LINE_BYTES);
   localparam logic [ADDR_W-1:0] PAGE_MASK = ~ADDR_W'(HAWK_PAGE_BYTES - 1);

   decomp_wb_state_t  state_q, state_nxt;
   logic [ADDR_W-1:0] base_q, base_nxt;
   logic [LCNT_W-1:0] line_cnt_q, line_cnt_nxt;
   axi_wr_reqpkt_t    req_q, req_nxt;
   axi_wr_resppkt_t   resp;
   logic              aw_done_q, aw_done_nxt;
   logic              w_done_q, w_done_nxt;
   logic              dc_wready_q, dc_wready_nxt;
   logic              done_q, busy_q, err_q;
   logic              issue;
   logic              b_err;
   logic [OUTST_W-1:0] outst;
   logic              outst_full_nxt;
   logic              outst_underflow;

   assign resp = '{bvalid: bvalid, bresp: bresp};

   hawk_outst_cnt #(
      .MAX_OUTST (MAX_OUTST),
      .CNT_W     (OUTST_W)
   ) u_outst_cnt (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .inc       (issue),
      .dec       (resp.bvalid),
      .cnt       (outst),
      .full_nxt  (outst_full_nxt),
      .underflow (outst_underflow)
   );

   assign b_err = resp.bvalid && ((resp.bresp != AXI_RESP_OKAY) || outst_underflow);

   always_comb begin
      state_nxt    = state_q;
      base_nxt     = base_q;
      line_cnt_nxt = line_cnt_q;
      req_nxt      = req_q;
      aw_done_nxt  = aw_done_q;
      w_done_nxt   = w_done_q;
      issue        = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (decomp_start) begin
               base_nxt     = wb_page_addr & PAGE_MASK;
               line_cnt_nxt = '0;
               state_nxt    = ST_FILL;
            end
         end
         ST_FILL: begin
            if (dc_wready_q && dc_wvalid) begin
               req_nxt.wdata   = HAWK_DATA_W'(dc_wdata);
               // line_cnt < PAGE_LINES, so the offset stays inside the page
               req_nxt.addr    = HAWK_ADDR_W'(base_q + (ADDR_W'(line_cnt_q) << LINE_SHIFT));
               req_nxt.awvalid = 1'b1;
               req_nxt.wvalid  = 1'b1;
               aw_done_nxt     = 1'b0;
               w_done_nxt      = 1'b0;
               state_nxt       = ST_SEND;
            end
         end
         ST_SEND: begin
            req_nxt.awvalid = req_q.awvalid && !awready;
            req_nxt.wvalid  = req_q.wvalid && !wready;
            aw_done_nxt     = aw_done_q || (req_q.awvalid && awready);
            w_done_nxt      = w_done_q || (req_q.wvalid && wready);
            if (aw_done_nxt && w_done_nxt) begin
               issue        = 1'b1;
               aw_done_nxt  = 1'b0;
               w_done_nxt   = 1'b0;
               line_cnt_nxt = line_cnt_q + LCNT_W'(1);
               state_nxt    = (line_cnt_nxt == LCNT_W'(PAGE_LINES)) ? ST_DRAIN : ST_FILL;
            end
         end
         ST_DRAIN: begin
            if (outst == '0) begin
               state_nxt = ST_DONE;
            end
         end
         ST_DONE: begin
            state_nxt = ST_WAIT_LOW;
         end
         ST_WAIT_LOW: begin
            if (!decomp_start) begin
               state_nxt = ST_IDLE;
            end
         end
         ST_ERROR: begin
            state_nxt = ST_ERROR;
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase

      if (b_err) begin
         state_nxt       = ST_ERROR;
         req_nxt.awvalid = 1'b0;
         req_nxt.wvalid  = 1'b0;
      end
   end

   assign dc_wready_nxt = (state_nxt == ST_FILL) && !outst_full_nxt;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= ST_IDLE;
         base_q      <= '0;
         line_cnt_q  <= '0;
         req_q       <= '0;
         aw_done_q   <= 1'b0;
         w_done_q    <= 1'b0;
         dc_wready_q <= 1'b0;
         done_q      <= 1'b0;
         busy_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_nxt;
         base_q      <= base_nxt;
         line_cnt_q  <= line_cnt_nxt;
         req_q       <= req_nxt;
         aw_done_q   <= aw_done_nxt;
         w_done_q    <= w_done_nxt;
         dc_wready_q <= dc_wready_nxt;
         done_q      <= (state_nxt == ST_DONE);
         busy_q      <= (state_nxt != ST_IDLE);
         err_q       <= err_q || b_err;
      end
   end

`ifdef HAWK_DECOMP_WB_STATS_EN
   logic [31:0] cyc_q, stall_q;
   logic        active, stall;

   assign active = (state_q == ST_FILL) || (state_q == ST_SEND) ||
                   (state_q == ST_DRAIN) || (state_q == ST_DONE);
   assign stall  = (req_q.awvalid && !awready) || (req_q.wvalid && !wready);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cyc_q   <= '0;
         stall_q <= '0;
      end else if ((state_q == ST_IDLE) && (state_nxt == ST_FILL)) begin
         cyc_q   <= '0;
         stall_q <= '0;
      end else begin
         if (active && (cyc_q != '1)) begin
            cyc_q <= cyc_q + 32'd1;
         end
         if (stall && (stall_q != '1)) begin
            stall_q <= stall_q + 32'd1;
         end
      end
   end

   assign wb_cycles       = cyc_q;
   assign wb_stall_cycles = stall_q;
`endif

   assign dc_wready   = dc_wready_q;
   assign awaddr      = ADDR_W'(req_q.addr);
   assign awvalid     = req_q.awvalid;
   assign wdata       = DATA_W'(req_q.wdata);
   assign wvalid      = req_q.wvalid;
   assign wlast       = req_q.wvalid;
   assign wstrb       = '1;
   assign awlen       = AXI_AWLEN_SINGLE;
   assign awsize      = AXI_AWSIZE_64B;
   assign awburst     = AXI_BURST_INCR;
   assign bready      = 1'b1;
   assign decomp_done = done_q;
   assign wb_busy     = busy_q;
   assign wb_err      = err_q;

endmodule

// File: tb/tb_hawk_decomp_wb.sv
// Randomized scoreboard bench for hawk_decomp_wb: page model predicts every AW/W beat.
module tb_hawk_decomp_wb;

   logic         clk_i = 1'b0;
   logic         rst_i = 1'b1;
   logic         decomp_start = 1'b0;
   logic [63:0]  wb_page_addr = '0;
   logic [511:0] dc_wdata = '0;
   logic         dc_wvalid = 1'b0;
   logic         dc_wready;
   logic [63:0]  awaddr;
   logic [7:0]   awlen;
   logic [2:0]   awsize;
   logic [1:0]   awburst;
   logic         awvalid;
   logic         awready = 1'b1;
   logic [511:0] wdata;
   logic [63:0]  wstrb;
   logic         wlast, wvalid;
   logic         wready = 1'b1;
   logic         bvalid = 1'b0;
   logic [1:0]   bresp = 2'b00;
   logic         bready, decomp_done, wb_busy, wb_err;

   always #5 clk_i = ~clk_i;

   hawk_decomp_wb dut (
      .clk_i(clk_i), .rst_i(rst_i), .decomp_start(decomp_start), .wb_page_addr(wb_page_addr),
      .dc_wdata(dc_wdata), .dc_wvalid(dc_wvalid), .dc_wready(dc_wready),
      .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
      .awvalid(awvalid), .awready(awready),
      .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
      .bvalid(bvalid), .bresp(bresp), .bready(bready),
      .decomp_done(decomp_done), .wb_busy(wb_busy), .wb_err(wb_err)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [511:0] rand512();
      logic [511:0] r;
      for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
      return r;
   endfunction

   // stimulus controls (main writes, other processes read)
   bit   rdy_rand = 0, dc_rand = 0, b_rand = 0;
   bit   aw_force = 1, w_force = 1;
   int   b_limit = 1 << 30;
   int   err_idx = -1;
   int   page_id = 0;
   logic [63:0] page_base = '0;

   // monitor-owned model state
   logic [63:0]  exp_addr_q[$];
   logic [511:0] exp_data_q[$];
   int cyc = 0, mon_page = 0, line_idx = 0;
   int aw_cnt = 0, w_cnt = 0, aw_pg = 0, w_pg = 0, b_pg = 0;
   int done_cnt = 0, dc_hs_total = 0;
   int last_b_cyc = 0, last_hs_cyc = 0, first_aw_cyc = 0, last_aw_cyc = 0;
   bit prev_aw_stall = 0, prev_w_stall = 0;
   logic [63:0]  prev_awaddr = '0;
   logic [511:0] prev_wdata = '0;

   // responder-owned
   int b_sent = 0;

   always @(negedge clk_i) begin
      cyc++;
      if (rst_i) begin
         exp_addr_q.delete();
         exp_data_q.delete();
         line_idx = 0; aw_cnt = 0; w_cnt = 0; aw_pg = 0; w_pg = 0; b_pg = 0;
         prev_aw_stall = 0; prev_w_stall = 0;
      end else begin
         if (page_id != mon_page) begin
            mon_page = page_id;
            line_idx = 0; aw_pg = 0; w_pg = 0; b_pg = 0;
         end
         if (prev_aw_stall) begin
            chk("aw_hold_valid", awvalid, 1'b1);
            chk("aw_hold_addr", awaddr, prev_awaddr);
         end
         if (prev_w_stall) begin
            chk("w_hold_valid", wvalid, 1'b1);
            chk("w_hold_data", wdata, prev_wdata);
         end
         if (dc_wvalid && dc_wready) begin
            chk("dc_line_in_page", line_idx < 64, 1'b1);
            if (line_idx < 64) begin
               exp_addr_q.push_back(page_base + 64'(line_idx) * 64'd64);
               exp_data_q.push_back(dc_wdata);
            end
            line_idx++;
            dc_hs_total++;
            last_hs_cyc = cyc;
         end
         if (awvalid && awready) begin
            chk("aw_expected", exp_addr_q.size() > 0, 1'b1);
            if (exp_addr_q.size() > 0) chk("awaddr", awaddr, exp_addr_q.pop_front());
            chk("aw_fields", {awlen, awsize, awburst}, {8'd0, 3'd6, 2'b01});
            if (aw_pg == 0) first_aw_cyc = cyc;
            last_aw_cyc = cyc;
            aw_cnt++; aw_pg++;
         end
         if (wvalid && wready) begin
            chk("w_expected", exp_data_q.size() > 0, 1'b1);
            if (exp_data_q.size() > 0) chk("wdata", wdata, exp_data_q.pop_front());
            chk("wstrb_wlast", {wstrb, wlast}, {64'hFFFF_FFFF_FFFF_FFFF, 1'b1});
            w_cnt++; w_pg++;
         end
         if (bvalid) begin
            b_pg++;
            last_b_cyc = cyc;
         end
         if (decomp_done) begin
            done_cnt++;
            chk("done_after_last_b", cyc - last_b_cyc, 2);
            chk("done_b_count", b_pg, 64);
            chk("done_aw_count", aw_pg, 64);
            chk("done_queues_empty", exp_addr_q.size() + exp_data_q.size(), 0);
         end
         prev_aw_stall = awvalid && !awready;
         prev_awaddr   = awaddr;
         prev_w_stall  = wvalid && !wready;
         prev_wdata    = wdata;
      end
   end

   // readiness and decompressor stream
   initial begin
      int dc_seen = 0;
      forever begin
         @(posedge clk_i); #1;
         awready = rdy_rand ? 1'($urandom_range(0, 1)) : aw_force;
         wready  = rdy_rand ? 1'($urandom_range(0, 1)) : w_force;
         if (!dc_wvalid || (dc_hs_total != dc_seen)) begin
            dc_seen   = dc_hs_total;
            dc_wvalid = !dc_rand || ($urandom_range(0, 2) != 0);
            dc_wdata  = rand512();
         end
      end
   end

   // B responder: one B per completed AW+W pair
   initial begin
      forever begin
         @(posedge clk_i); #1;
         bvalid = 1'b0;
         bresp  = 2'b00;
         if (rst_i) begin
            b_sent = 0;
         end else if ((b_sent < aw_cnt) && (b_sent < w_cnt) && (b_sent < b_limit) &&
                      (!b_rand || ($urandom_range(0, 2) == 0))) begin
            bvalid = 1'b1;
            bresp  = (b_sent == err_idx) ? 2'b10 : 2'b00;
            b_sent++;
         end
      end
   end

   task automatic neg();
      @(negedge clk_i); #1;
   endtask

   task automatic drive_edge();
      @(posedge clk_i); #1;
   endtask

   task automatic start_page(input logic [63:0] a);
      drive_edge();
      wb_page_addr = a;
      page_base    = a & ~64'hFFF;
      page_id++;
      decomp_start = 1'b1;
   endtask

   task automatic wait_done(input string name, input int bound);
      int d0 = done_cnt;
      int n  = 0;
      while ((done_cnt == d0) && (n < bound)) begin
         neg();
         n++;
      end
      chk(name, done_cnt, d0 + 1);
   endtask

   task automatic check_reset_outputs(input string name);
      chk(name, {awvalid, wvalid, dc_wready, decomp_done, wb_err, wb_busy, bready},
                {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1});
   endtask

   task automatic pulse_reset(input string name);
      drive_edge();
      rst_i = 1'b1;
      decomp_start = 1'b0;
      neg();
      neg();
      check_reset_outputs(name);
      drive_edge();
      rst_i = 1'b0;
   endtask

   initial begin
      int n;
      int d0;
      repeat (3) @(posedge clk_i);
      neg();
      check_reset_outputs("reset_values");
      drive_edge();
      rst_i = 1'b0;

      // page at 0x8000_1234, everything ready, one line per two cycles
      start_page(64'h8000_1234);
      wait_done("t1_done", 2000);
      chk("t1_aw_span", last_aw_cyc - first_aw_cyc, 126);
      d0 = done_cnt;

      // start held after done must not retrigger
      repeat (3) neg();
      chk("t5_no_retrigger", {done_cnt, aw_pg, line_idx}, {d0, 32'd64, 32'd64});
      chk("t5_busy_wait_low", wb_busy, 1'b1);
      drive_edge();
      decomp_start = 1'b0;
      repeat (3) neg();
      chk("t5_idle", wb_busy, 1'b0);

      // second page with random handshakes
      rdy_rand = 1; dc_rand = 1; b_rand = 1;
      start_page(64'h9000_0000);
      wait_done("t5_done_page2", 6000);
      drive_edge();
      decomp_start = 1'b0;
      rdy_rand = 0; dc_rand = 0; b_rand = 0;
      repeat (3) neg();

      // AW stalled while W completes
      aw_force = 0; w_force = 1;
      start_page({32'h0, $urandom} << 12);
      n = 0;
      while (!awvalid && (n < 50)) begin neg(); n++; end
      chk("t2_awvalid_seen", awvalid, 1'b1);
      for (int i = 0; i < 5; i++) begin
         neg();
         chk("t2_aw_stalled", {awvalid, wvalid}, {1'b1, 1'b0});
      end
      chk("t2_single_w", {aw_pg, w_pg}, {32'd0, 32'd1});
      aw_force = 1;
      wait_done("t2_done", 2000);
      drive_edge();
      decomp_start = 1'b0;
      repeat (3) neg();

      // B withheld: outstanding limit
      b_limit = b_sent;
      start_page(64'hA000_5000);
      repeat (40) neg();
      chk("t3_aw_issued", aw_pg, 4);
      chk("t3_lines_taken", line_idx, 4);
      chk("t3_dc_wready_low", dc_wready, 1'b0);
      drive_edge();
      b_limit = b_sent + 1;
      n = 0;
      while ((line_idx < 5) && (n < 20)) begin neg(); n++; end
      chk("t3_fifth_line", line_idx, 5);
      chk("t3_accept_after_b", last_hs_cyc - last_b_cyc, 1);
      b_limit = 1 << 30;
      wait_done("t3_done", 2000);
      drive_edge();
      decomp_start = 1'b0;
      repeat (3) neg();

      // SLVERR on line 10
      err_idx = b_sent + 10;
      d0 = done_cnt;
      start_page(64'hB000_0000);
      n = 0;
      while (!wb_err && (n < 500)) begin neg(); n++; end
      chk("t4_err_set", wb_err, 1'b1);
      for (int i = 0; i < 8; i++) begin
         neg();
         chk("t4_err_quiet", {wb_err, awvalid, wvalid, dc_wready, decomp_done},
                             {1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
      end
      chk("t4_no_done", done_cnt, d0);
      chk("t4_err_line", b_pg, 11);
      pulse_reset("t4_reset_clears");
      err_idx = -1;
      repeat (2) neg();

      // reset mid-page, then a fresh full page
      start_page(64'hC123_4000);
      n = 0;
      while ((line_idx < 30) && (n < 500)) begin neg(); n++; end
      chk("t6_reached_line30", line_idx >= 30, 1'b1);
      pulse_reset("t6_reset_midpage");
      repeat (2) neg();
      rdy_rand = 1; dc_rand = 1; b_rand = 1;
      start_page({32'h0, $urandom} << 12 | 64'h0ABC);
      wait_done("t6_done_after_reset", 6000);
      drive_edge();
      decomp_start = 1'b0;
      repeat (4) neg();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
      $fatal(1, "watchdog");
   end

endmodule
